// File: rtl/fetch_unit.sv
// Instruction-fetch stage: reads the word at the current PC over a req/ack
// handshake, presents it to decode on a valid/ready interface, and steers the
// PC register with increment/load pulses (including execute-stage redirects).
// A request left unanswered for TIMEOUT cycles parks the unit in a sticky
// error state that only reset clears.
`timescale 1ns/1ps
module fetch_unit #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_inc,
  output logic              pc_write,
  output logic [ADDR_W-1:0] pc_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [DATA_W-1:0] ir_out,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic              fetch_err
);

  localparam int unsigned     CntW   = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StReq, StHold, StFlush, StErr} state_e;

  state_e              r_state, w_state_d;
  logic [CntW-1:0]     r_cnt, w_cnt_d;
  logic                r_mem_req, w_mem_req_d;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_d;
  logic [DATA_W-1:0]   r_ir_out, w_ir_out_d;
  logic [ADDR_W-1:0]   r_ir_pc, w_ir_pc_d;
  logic                r_ir_valid, w_ir_valid_d;
  logic                r_pc_inc, w_pc_inc_d;
  logic                r_pc_write, w_pc_write_d;
  logic [ADDR_W-1:0]   r_pc_target, w_pc_target_d;
  logic                r_err, w_err_d;

  // State and all output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_ir_out    <= '0;
      r_ir_pc     <= '0;
      r_ir_valid  <= 1'b0;
      r_pc_inc    <= 1'b0;
      r_pc_write  <= 1'b0;
      r_pc_target <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_mem_req   <= w_mem_req_d;
      r_mem_addr  <= w_mem_addr_d;
      r_ir_out    <= w_ir_out_d;
      r_ir_pc     <= w_ir_pc_d;
      r_ir_valid  <= w_ir_valid_d;
      r_pc_inc    <= w_pc_inc_d;
      r_pc_write  <= w_pc_write_d;
      r_pc_target <= w_pc_target_d;
      r_err       <= w_err_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_mem_req_d   = r_mem_req;
    w_mem_addr_d  = r_mem_addr;
    w_ir_out_d    = r_ir_out;
    w_ir_pc_d     = r_ir_pc;
    w_ir_valid_d  = r_ir_valid;
    w_pc_inc_d    = 1'b0;
    w_pc_write_d  = 1'b0;
    w_pc_target_d = r_pc_target;
    w_err_d       = r_err;

    // A redirect always produces a load pulse; in FLUSH the last one wins.
    if (branch_valid && (r_state != StErr)) begin
      w_pc_write_d  = 1'b1;
      w_pc_target_d = branch_target;
    end

    case (r_state)
      StIdle: begin
        // Launch only once no PC update is in flight, so pc_in has settled.
        if (!branch_valid && !r_pc_write && !r_pc_inc) begin
          w_mem_req_d  = 1'b1;
          w_mem_addr_d = pc_in;
          w_cnt_d      = '0;
          w_state_d    = StReq;
        end
      end

      StReq: begin
        if (mem_ack) begin
          w_mem_req_d = 1'b0;
          if (branch_valid) begin
            w_state_d = StIdle;  // wrong-path data dropped
          end else begin
            w_ir_out_d   = mem_rdata;
            w_ir_pc_d    = r_mem_addr;
            w_ir_valid_d = 1'b1;
            w_pc_inc_d   = 1'b1;
            w_state_d    = StHold;
          end
        end else if (branch_valid) begin
          w_cnt_d   = '0;
          w_state_d = StFlush;  // request must still complete
        end else if (r_cnt == CntMax) begin
          w_mem_req_d  = 1'b0;
          w_err_d      = 1'b1;
          w_ir_valid_d = 1'b0;
          w_state_d    = StErr;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end

      StHold: begin
        // A branch voids any same-cycle handshake; decode squashes it.
        if (branch_valid || ir_ready) begin
          w_ir_valid_d = 1'b0;
          w_state_d    = StIdle;
        end
      end

      StFlush: begin
        if (mem_ack) begin
          w_mem_req_d = 1'b0;
          w_state_d   = StIdle;
        end else if (r_cnt == CntMax) begin
          w_mem_req_d  = 1'b0;
          w_err_d      = 1'b1;
          w_ir_valid_d = 1'b0;
          w_state_d    = StErr;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end

      StErr: begin
        w_mem_req_d  = 1'b0;
        w_ir_valid_d = 1'b0;
        w_err_d      = 1'b1;
      end

      default: w_state_d = StIdle;
    endcase
  end

  assign pc_inc    = r_pc_inc;
  assign pc_write  = r_pc_write;
  assign pc_target = r_pc_target;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign ir_out    = r_ir_out;
  assign ir_pc     = r_ir_pc;
  assign ir_valid  = r_ir_valid;
  assign fetch_err = r_err;

endmodule
